// File: rtl/div_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// div_ctrl_pkg
// Purpose : shared definitions for the iterative radix-2 restoring divider.
// Contents: FSM state encoding (3 bits), fixed divide latency and the quotient
//           value forced on divide-by-zero.
// ---------------------------------------------------------------------------
package div_ctrl_pkg;

    typedef enum logic [2:0] {
        DIV_IDLE = 3'd0,
        DIV_PREP = 3'd1,
        DIV_RUN  = 3'd2,
        DIV_FIX  = 3'd3,
        DIV_DONE = 3'd4
    } div_state_e;

    // Cycles from the start cycle to the cycle in which done is high.
    localparam int unsigned DIV_LATENCY = 35;

    // Quotient reported for a zero divisor (all ones at 32 bits).
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// Purpose : one combinational restoring-division iteration.
// Ports   : rem      - partial remainder (always < div for a nonzero divisor)
//           q        - quotient/shift register; its MSB is the next dividend bit
//           div      - divisor magnitude
//           rem_next - partial remainder after this step
//           q_next   - shift register with the new quotient bit in the LSB
// ---------------------------------------------------------------------------
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH+1:0] w_trial;
    logic             w_borrow;

    always_comb begin
        w_shifted = {rem, q[WIDTH-1]};
        // Two guard bits so the top bit of the difference is a clean borrow flag.
        w_trial   = {1'b0, w_shifted} - {2'b00, div};
        w_borrow  = w_trial[WIDTH+1];
        // On restore the shifted value is below div, so it fits in WIDTH bits.
        rem_next  = w_borrow ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
        q_next    = {q[WIDTH-2:0], ~w_borrow};
    end

endmodule

// File: rtl/div_ctrl.sv
// ---------------------------------------------------------------------------
// div_ctrl
// Purpose : sequences a restoring divider over WIDTH iterations for DIV/DIVU
//           and presents remainder on hi and quotient on lo.
// Ports   : clk, resetn (synchronous, active low)
//           start, signed_div, a, b - request and operands, sampled with start
//           cancel                  - flush; wins over start, aborts any state
//           busy                    - high in PREP, RUN, FIX (pipeline stall)
//           done                    - one-cycle pulse in DONE
//           hi, lo, div_zero        - results, held until the next completed divide
// ---------------------------------------------------------------------------
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    div_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic             r_neg_rem;
    logic             r_neg_quot;
    logic             r_zero;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_div;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_div_zero;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_rem_fix;

    // The most negative value negates to itself, which is its correct
    // magnitude when read as unsigned.
    always_comb begin
        w_abs_a    = (r_signed && r_a[WIDTH-1]) ? -r_a : r_a;
        w_abs_b    = (r_signed && r_b[WIDTH-1]) ? -r_b : r_b;
        w_quot_fix = r_neg_quot ? -r_q : r_q;
        w_rem_fix  = r_neg_rem ? -r_rem : r_rem;
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem      (r_rem),
        .q        (r_q),
        .div      (r_div),
        .rem_next (w_rem_next),
        .q_next   (w_q_next)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= DIV_IDLE;
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_signed   <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_neg_quot <= 1'b0;
            r_zero     <= 1'b0;
            r_rem      <= '0;
            r_q        <= '0;
            r_div      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else if (cancel) begin
            r_state <= DIV_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE, DIV_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_signed   <= signed_div;
                        r_neg_rem  <= signed_div & a[WIDTH-1];
                        r_neg_quot <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_busy     <= 1'b1;
                        r_state    <= DIV_PREP;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= DIV_IDLE;
                    end
                end
                DIV_PREP: begin
                    r_q     <= w_abs_a;
                    r_div   <= w_abs_b;
                    r_rem   <= '0;
                    r_cnt   <= '0;
                    r_zero  <= (r_b == '0);
                    r_state <= DIV_RUN;
                end
                DIV_RUN: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    // Zero divisor overrides whatever the datapath produced.
                    if (r_zero) begin
                        r_lo <= '1;
                        r_hi <= r_a;
                    end else begin
                        r_lo <= w_quot_fix;
                        r_hi <= w_rem_fix;
                    end
                    r_div_zero <= r_zero;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                    r_state    <= DIV_DONE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= DIV_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_ctrl
// Purpose : directed self-checking bench for div_ctrl.
// ---------------------------------------------------------------------------
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int checks;
    int failures;

    div_ctrl #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .cancel     (cancel),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .div_zero   (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request in the current cycle (cycle 0).
    task automatic launch(input logic [31:0] va, input logic [31:0] vb, input logic sg);
        a          = va;
        b          = vb;
        signed_div = sg;
        start      = 1'b1;
    endtask

    // Run from cycle 0 to the done cycle and check timing and results.
    // Leaves the bench mid-cycle in the done cycle.
    task automatic run_op(input string tag, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input logic exp_dz);
        int first;
        logic bad;
        first = 0;
        bad   = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0BAD_F00D;
        for (int k = 1; k <= 40 && first == 0; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (done === 1'b1) first = k;
            else if (busy !== 1'b1 || k > 34) bad = 1'b1;
        end
        chk({tag, "_latency"}, first, DIV_LATENCY);
        chk({tag, "_busy_run"}, {31'd0, bad}, 32'd0);
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_lo"}, lo, exp_lo);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_dz"}, {31'd0, div_zero}, {31'd0, exp_dz});
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    logic seen;

    initial begin
        checks     = 0;
        failures   = 0;
        resetn     = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        a          = '0;
        b          = '0;
        cancel     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_dz", {31'd0, div_zero}, 32'd0);
        resetn = 1'b1;
        step();

        launch(32'd7, 32'd2, 1'b0);
        run_op("u7_2", 32'd3, 32'd1, 1'b0);
        step();
        chk("done_pulse", {31'd0, done}, 32'd0);

        launch(32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op("sm7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        step();

        launch(32'd7, 32'hFFFF_FFFE, 1'b1);
        run_op("s7_m2", 32'hFFFF_FFFD, 32'd1, 1'b0);
        step();

        launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op("smin_m1", 32'h8000_0000, 32'd0, 1'b0);
        step();

        launch(32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op("umax_1", 32'hFFFF_FFFF, 32'd0, 1'b0);
        step();

        launch(32'h1234_5678, 32'd0, 1'b1);
        run_op("sdz", DIV_ZERO_QUOT, 32'h1234_5678, 1'b1);
        step();

        launch(32'h1234_5678, 32'd0, 1'b0);
        run_op("udz", DIV_ZERO_QUOT, 32'h1234_5678, 1'b1);
        step();

        launch(32'd100, 32'd7, 1'b0);
        run_op("u100_7", 32'd14, 32'd2, 1'b0);
        step();

        // Cancel in cycle 10 of a 50/3.
        launch(32'd50, 32'd3, 1'b0);
        step();
        start = 1'b0;
        repeat (9) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
            step();
        end
        chk("cancel_no_done", {31'd0, seen}, 32'd0);
        chk("cancel_lo", lo, 32'd14);
        chk("cancel_hi", hi, 32'd2);
        chk("cancel_dz", {31'd0, div_zero}, 32'd0);

        // Reset in cycle 10 of a 50/3.
        launch(32'd50, 32'd3, 1'b0);
        step();
        start = 1'b0;
        repeat (9) step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_hi", hi, 32'd0);
        chk("mrst_lo", lo, 32'd0);
        chk("mrst_dz", {31'd0, div_zero}, 32'd0);
        step();

        // Back-to-back: new start in the DONE cycle.
        launch(32'd100, 32'd7, 1'b0);
        run_op("b2b_first", 32'd14, 32'd2, 1'b0);
        launch(32'd9, 32'd4, 1'b0);
        run_op("b2b_second", 32'd2, 32'd1, 1'b0);
        step();
        chk("b2b_pulse", {31'd0, done}, 32'd0);

        // Start together with cancel in IDLE does nothing.
        launch(32'd50, 32'd3, 1'b0);
        cancel = 1'b1;
        step();
        start  = 1'b0;
        cancel = 1'b0;
        chk("sc_busy", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
            step();
        end
        chk("sc_no_op", {31'd0, seen}, 32'd0);
        chk("sc_lo", lo, 32'd2);
        chk("sc_hi", hi, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
